// File: rtl/pattern_gen.sv
// pattern_gen: test-pattern pixel source sitting beside the HDMI timing generator.
// Pixels are combinational from x/y/de; mode and box state only move on frame ticks.
module pattern_gen #(
    parameter int         ACTIVE_WIDTH  = 800,
    parameter int         ACTIVE_HEIGHT = 600,
    parameter int         BOX_SIZE      = 32,
    parameter int         BOX_STEP      = 2,
    parameter logic [2:0] BOX_COLOUR    = 3'b110,
    parameter logic       VS_POL        = 1'b1
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        de,
    input  logic        vs,
    output logic [2:0]  pixel_data,
    input  logic        mode_valid,
    input  logic [1:0]  mode_data,
    output logic        mode_ready,
    output logic [15:0] frame_count
);

    localparam int BAR_W = ACTIVE_WIDTH / 8;

    typedef enum logic [1:0] {
        MODE_BLACK = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_BOX   = 2'd3
    } mode_t;

    typedef enum logic {
        HS_IDLE    = 1'b0,
        HS_PENDING = 1'b1
    } hs_state_t;

    // dir = 1 means the box is moving towards larger coordinates.
    typedef struct packed {
        logic       dir;
        logic [9:0] pos;
    } axis_t;

    function automatic logic [2:0] bar_index(input logic [9:0] xv);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (int'(xv) >= i * BAR_W) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // Bound checks run at 11 bits so pos+STEP+SIZE never wraps.
    function automatic axis_t step_axis(input axis_t cur, input int limit);
        axis_t nxt;
        nxt = cur;
        if (cur.dir) begin
            if (({1'b0, cur.pos} + 11'(BOX_STEP) + 11'(BOX_SIZE)) > 11'(limit)) begin
                nxt.pos = 10'(limit - BOX_SIZE);
                nxt.dir = 1'b0;
            end else begin
                nxt.pos = cur.pos + 10'(BOX_STEP);
            end
        end else begin
            if ({1'b0, cur.pos} < 11'(BOX_STEP)) begin
                nxt.pos = 10'd0;
                nxt.dir = 1'b1;
            end else begin
                nxt.pos = cur.pos - 10'(BOX_STEP);
            end
        end
        return nxt;
    endfunction

    function automatic logic in_span(input logic [9:0] p, input logic [9:0] lo);
        return ({1'b0, p} >= {1'b0, lo}) && ({1'b0, p} < ({1'b0, lo} + 11'(BOX_SIZE)));
    endfunction

    logic        vs_q, vs_d;
    mode_t       mode_q, mode_d;
    hs_state_t   hs_state_q, hs_state_d;
    logic [1:0]  pend_mode_q, pend_mode_d;
    axis_t       box_x_q, box_x_d;
    axis_t       box_y_q, box_y_d;
    logic [15:0] frame_count_q, frame_count_d;

    logic        tick;
    logic        accept;
    logic [2:0]  bar_colour;
    logic        box_hit;

    assign tick        = (vs == VS_POL) && (vs_q != VS_POL);
    assign mode_ready  = (hs_state_q == HS_IDLE);
    assign accept      = mode_valid && mode_ready;
    assign frame_count = frame_count_q;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            vs_q          <= ~VS_POL;
            mode_q        <= MODE_BARS;
            hs_state_q    <= HS_IDLE;
            pend_mode_q   <= 2'd0;
            box_x_q       <= '{dir: 1'b1, pos: 10'd0};
            box_y_q       <= '{dir: 1'b1, pos: 10'd0};
            frame_count_q <= 16'd0;
        end else begin
            vs_q          <= vs_d;
            mode_q        <= mode_d;
            hs_state_q    <= hs_state_d;
            pend_mode_q   <= pend_mode_d;
            box_x_q       <= box_x_d;
            box_y_q       <= box_y_d;
            frame_count_q <= frame_count_d;
        end
    end

    // A request accepted on a tick cycle is only pending from the next cycle,
    // so it waits for the following tick rather than the current one.
    always_comb begin
        hs_state_d  = hs_state_q;
        pend_mode_d = pend_mode_q;
        mode_d      = mode_q;
        unique case (hs_state_q)
            HS_IDLE: begin
                if (accept) begin
                    pend_mode_d = mode_data;
                    hs_state_d  = HS_PENDING;
                end
            end
            HS_PENDING: begin
                if (tick) begin
                    mode_d     = mode_t'(pend_mode_q);
                    hs_state_d = HS_IDLE;
                end
            end
            default: hs_state_d = HS_IDLE;
        endcase
    end

    always_comb begin
        vs_d          = vs;
        box_x_d       = box_x_q;
        box_y_d       = box_y_q;
        frame_count_d = frame_count_q;
        if (tick) begin
            box_x_d       = step_axis(box_x_q, ACTIVE_WIDTH);
            box_y_d       = step_axis(box_y_q, ACTIVE_HEIGHT);
            frame_count_d = frame_count_q + 16'd1;
        end
    end

    always_comb begin
        bar_colour = bar_index(x);
        box_hit    = in_span(x, box_x_q.pos) && in_span(y, box_y_q.pos);
        pixel_data = 3'b000;
        if (de) begin
            unique case (mode_q)
                MODE_BLACK: pixel_data = 3'b000;
                MODE_BARS:  pixel_data = bar_colour;
                MODE_CHECK: pixel_data = (x[5] ^ y[5]) ? 3'b111 : 3'b000;
                MODE_BOX:   pixel_data = box_hit ? BOX_COLOUR : bar_colour;
                default:    pixel_data = 3'b000;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_gen.sv
// Bench for pattern_gen: directed scenarios plus randomized frames checked
// against an arithmetic model of modes, handshake, box motion and frame count.
module tb_pattern_gen;

    logic        clk_in;
    logic        rst_n;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        de;
    logic        vs;
    logic [2:0]  pixel_data;
    logic        mode_valid;
    logic [1:0]  mode_data;
    logic        mode_ready;
    logic [15:0] frame_count;

    int n_vec;
    int n_bad;

    // Reference state
    int m_mode;
    int m_pend;
    int m_bx, m_by, m_dx, m_dy;
    int m_fc;
    bit m_vsq;

    pattern_gen dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .x           (x),
        .y           (y),
        .de          (de),
        .vs          (vs),
        .pixel_data  (pixel_data),
        .mode_valid  (mode_valid),
        .mode_data   (mode_data),
        .mode_ready  (mode_ready),
        .frame_count (frame_count)
    );

    initial clk_in = 1'b0;
    always #10 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 1;
        m_pend = -1;
        m_bx = 0; m_by = 0;
        m_dx = 1; m_dy = 1;
        m_fc = 0;
        m_vsq = 1'b0;
    endtask

    function automatic int exp_pix(input int xx, input int yy, input bit d);
        int bar;
        if (!d) return 0;
        bar = xx / 100;
        if (bar > 7) bar = 7;
        case (m_mode)
            0: return 0;
            1: return bar;
            2: return ((((xx / 32) % 2) ^ ((yy / 32) % 2)) != 0) ? 7 : 0;
            default: begin
                if (xx >= m_bx && xx < m_bx + 32 && yy >= m_by && yy < m_by + 32) return 6;
                return bar;
            end
        endcase
    endfunction

    task automatic move(inout int p, inout int dir, input int lim);
        if (dir > 0) begin
            if (p + 2 + 32 > lim) begin p = lim - 32; dir = -1; end
            else p = p + 2;
        end else begin
            if (p < 2) begin p = 0; dir = 1; end
            else p = p - 2;
        end
    endtask

    task automatic set_in(input int xx, input int yy, input bit d, input bit v,
                          input bit mv, input int md);
        x = 10'(xx);
        y = 10'(yy);
        de = d;
        vs = v;
        mode_valid = mv;
        mode_data = 2'(md);
    endtask

    // Check outputs mid-cycle, then advance the model across the coming edge.
    task automatic run_cycle();
        bit tk;
        bit acc;
        @(negedge clk_in);
        chk("pixel", 32'(pixel_data), exp_pix(int'(x), int'(y), de));
        chk("mode_ready", 32'(mode_ready), (m_pend < 0) ? 1 : 0);
        chk("frame_count", 32'(frame_count), m_fc);
        tk  = vs && !m_vsq;
        acc = mode_valid && (m_pend < 0);
        if (tk) begin
            if (m_pend >= 0) begin
                m_mode = m_pend;
                m_pend = -1;
            end
            move(m_bx, m_dx, 800);
            move(m_by, m_dy, 600);
            m_fc = (m_fc + 1) % 65536;
        end
        if (acc) m_pend = int'(mode_data);
        m_vsq = vs;
        @(posedge clk_in);
        #1;
    endtask

    task automatic vs_pulse(input int len, input bit mv, input int md);
        set_in(0, 0, 0, 1, mv, md);
        run_cycle();
        for (int i = 1; i < len; i++) begin
            set_in(0, 0, 0, 1, 0, 0);
            run_cycle();
        end
        set_in(0, 0, 0, 0, 0, 0);
        run_cycle();
    endtask

    task automatic probe(input string tag, input int xx, input int yy, input int exp);
        set_in(xx, yy, 1, 0, 0, 0);
        #1;
        chk(tag, 32'(pixel_data), exp);
    endtask

    task automatic rand_frame(input int npix, input bit allow_req);
        for (int i = 0; i < npix; i++) begin
            int xx;
            int yy;
            bit d;
            bit mv;
            d = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 1) == 1) begin
                xx = m_bx + int'($urandom_range(0, 35)) - 2;
                yy = m_by + int'($urandom_range(0, 35)) - 2;
            end else begin
                xx = int'($urandom_range(0, 799));
                yy = int'($urandom_range(0, 599));
            end
            if (xx < 0) xx = 0;
            if (xx > 799) xx = 799;
            if (yy < 0) yy = 0;
            if (yy > 599) yy = 599;
            if (!d) begin xx = 0; yy = 0; end
            mv = allow_req && ($urandom_range(0, 9) == 0);
            set_in(xx, yy, d, 0, mv, int'($urandom_range(0, 3)));
            run_cycle();
        end
        vs_pulse(int'($urandom_range(1, 6)), allow_req && ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 3)));
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("areset_fc", 32'(frame_count), 0);
        chk("areset_ready", 32'(mode_ready), 1);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_ready", 32'(mode_ready), 1);
        chk("rst_fc", 32'(frame_count), 0);
        rst_n = 1'b1;

        // Colour bars straight out of reset
        probe("bars_x0", 0, 0, 0);
        probe("bars_x150", 150, 0, 1);
        probe("bars_x799", 799, 0, 7);
        set_in(400, 0, 0, 0, 0, 0);
        #1;
        chk("de_low", 32'(pixel_data), 0);
        run_cycle();

        // One tick per pulse regardless of length
        vs_pulse(6, 0, 0);
        chk("fc_one", 32'(frame_count), 1);
        vs_pulse(3, 0, 0);
        chk("fc_two", 32'(frame_count), 2);

        // Mid-frame request is deferred to the tick
        set_in(32, 0, 1, 0, 1, 2);
        run_cycle();
        set_in(32, 0, 1, 0, 0, 0);
        #1;
        chk("ready_low", 32'(mode_ready), 0);
        chk("bars_hold", 32'(pixel_data), 0);
        run_cycle();
        set_in(0, 0, 0, 1, 0, 0);
        run_cycle();
        chk("ready_back", 32'(mode_ready), 1);
        set_in(0, 0, 0, 0, 0, 0);
        run_cycle();
        probe("check_32_0", 32, 0, 7);
        probe("check_32_32", 32, 32, 0);
        run_cycle();

        // Async reset drops pending mode and all state
        vs_pulse(2, 0, 0);
        vs_pulse(2, 0, 0);
        chk("fc_five", 32'(frame_count), 5);
        set_in(0, 0, 1, 0, 1, 0);
        run_cycle();
        set_in(0, 0, 0, 0, 0, 0);
        #1;
        chk("pend_ready", 32'(mode_ready), 0);
        async_reset();
        probe("areset_x0", 0, 0, 0);
        probe("areset_x150", 150, 0, 1);
        run_cycle();
        vs_pulse(2, 0, 0);
        probe("pend_dropped", 150, 0, 1);
        run_cycle();

        // Box drawing and handshake edges
        set_in(10, 10, 1, 0, 1, 3);
        run_cycle();
        vs_pulse(2, 0, 0);
        probe("box_in", 31, 31, 6);
        probe("box_out", 32, 0, 0);
        run_cycle();
        vs_pulse(2, 1, 2);
        chk("tick_acc_ready", 32'(mode_ready), 0);
        probe("tick_acc_hold", 31, 31, 6);
        run_cycle();
        set_in(31, 31, 1, 0, 1, 0);
        run_cycle();
        vs_pulse(2, 0, 0);
        probe("tick_acc_apply", 32, 0, 7);
        chk("ready_after", 32'(mode_ready), 1);
        run_cycle();
        vs_pulse(2, 0, 0);
        probe("ignored_req", 32, 0, 7);
        run_cycle();

        // Long run: box bounce on both axes, then random mode traffic
        set_in(0, 0, 0, 0, 0, 0);
        async_reset();
        set_in(0, 0, 1, 0, 1, 3);
        run_cycle();
        for (int f = 1; f <= 800; f++) begin
            rand_frame(4, f > 400);
            case (f)
                284: begin probe("by284_in", 570, 568, 6); probe("by284_out", 570, 567, 5); end
                285: begin probe("by285_in", 575, 568, 6); probe("by285_out", 575, 567, 5); end
                286: begin probe("by286_in", 575, 566, 6); probe("by286_out", 575, 565, 5); end
                384: begin probe("bx384_in", 768, 375, 6); probe("bx384_out", 767, 375, 7); end
                385: begin probe("bx385_in", 768, 375, 6); probe("bx385_out", 767, 375, 7); end
                386: begin probe("bx386_in", 766, 375, 6); probe("bx386_out", 765, 375, 7); end
                default: ;
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pattern_gen.md
# pattern_gen

Pixel source that sits directly upstream of the HDMI timing interface. It receives the interface's `x`, `y`, `de` and `vs`, and returns `pixel_data` combinationally in the same cycle. It draws one of four test patterns: black, colour bars, checkerboard, or colour bars with a bouncing box. A valid/ready mode port selects the pattern, and all state changes are deferred to frame boundaries so the picture never tears.

## Interface
- `ACTIVE_WIDTH`, 800, active pixels per line.
- `ACTIVE_HEIGHT`, 600, active lines per frame.
- `BOX_SIZE`, 32, box edge in pixels.
- `BOX_STEP`, 2, box movement per frame on each axis, in pixels.
- `BOX_COLOUR`, 3'b110, box fill colour.
- `VS_POL`, 1'b1, active level of `vs`.
- `clk_in`  in  1  pixel clock, the same clock as the timing interface.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `x`  in  10  active-area column. 0 when `de`=0.
- `y`  in  10  active-area row. 0 when `de`=0.
- `de`  in  1  active-area flag.
- `vs`  in  1  vertical sync, polarity given by `VS_POL`.
- `pixel_data`  out  3  RGB pixel, combinational from inputs and registered state.
- `mode_valid`  in  1  mode request valid.
- `mode_data`  in  2  requested mode.
- `mode_ready`  out  1  high when no mode change is pending.
- `frame_count`  out  16  count of frame ticks since reset.

## Operation
- **Frame tick**
  - `vs_q` holds `vs` delayed by one cycle.
  - tick = (`vs`==`VS_POL`) && (`vs_q`!=`VS_POL`).
  - One tick occurs per sync pulse, however long the pulse is.
- **Modes**
  - 0: black.
  - 1: colour bars.
    - BAR_W = `ACTIVE_WIDTH`/8 (integer division).
    - Pixel = bar index min(x/BAR_W, 7).
  - 2: checkerboard. Pixel = (x[5]^y[5]) ? 3'b111 : 3'b000.
  - 3: colour bars, with `BOX_COLOUR` drawn where box_x ≤ x < box_x+`BOX_SIZE` and box_y ≤ y < box_y+`BOX_SIZE`.
- **Output gating:** `pixel_data` = 3'b000 whenever `de`=0, in every mode.
- **Mode handshake**
  - A request is accepted when `mode_valid` && `mode_ready`.
  - On accept, `mode_data` is stored as pending, and `mode_ready` goes low from the next cycle.
  - The pending mode becomes current at the next tick after the accept cycle.
  - An accept in the same cycle as a tick is applied at the following tick, not that one.
  - `mode_ready` returns high the cycle after the applying tick.
  - `mode_valid` while `mode_ready`=0 is ignored.
- **Box motion:** updated on every tick in all modes. Axis X is described below; axis Y is identical with `ACTIVE_HEIGHT`.
  - Direction +, when box_x+`BOX_STEP`+`BOX_SIZE` > `ACTIVE_WIDTH`: box_x ← `ACTIVE_WIDTH`−`BOX_SIZE`, direction ← −.
  - Direction +, otherwise: box_x ← box_x+`BOX_STEP`.
  - Direction −, when box_x < `BOX_STEP`: box_x ← 0, direction ← +.
  - Direction −, otherwise: box_x ← box_x−`BOX_STEP`.
  - All bound comparisons are done at 11 bits so they cannot overflow.
- **Frame counter:** `frame_count` increments on every tick and wraps from 65535 to 0.

## Timing
- **Reset values** (all registers, applied asynchronously on `rst_n` low, with no clock needed):
  - mode = 1, no pending mode, `mode_ready` = 1.
  - box_x = box_y = 0, both directions +.
  - `vs_q` = ~`VS_POL`.
  - `frame_count` = 0.
- **Pixel latency:** zero cycles; `pixel_data` is combinational from `x`, `y`, `de`.
- **Tick updates:** mode, box and `frame_count` are registered on the tick cycle and become visible from the next cycle. That cycle is in vertical blanking, so no active pixel sees a partial update.
- **Reset mid-frame:** reset abandons any pending mode. After release, the first tick needs `vs` to be seen inactive→active; a pulse already in progress at release produces a tick only if `vs`==`VS_POL` at the first clock after release.

## Test plan
1. **Colour bars after reset.** Reset, then `de`=1, y=0.
   - x=0 → 0; x=150 → 1; x=799 → 7.
   - `de`=0 → 0.
   - `mode_ready`=1, `frame_count`=0.
2. **Single tick per pulse.** One `vs` pulse held active for 6 cycles.
   - Exactly one tick: `frame_count`=1, box=(2,2).
   - A second pulse gives `frame_count`=2, box=(4,4).
3. **Box bounce.**
   - After 284 ticks box_y=568; tick 285 → box_y=568, direction −; tick 286 → box_y=566.
   - After 384 ticks box_x=768; tick 385 → box_x=768, direction −; tick 386 → box_x=766.
4. **Deferred mode change.** Mid-frame request `mode_data`=2.
   - `mode_ready` is 0 from the next cycle.
   - Pixels stay as bars until the tick.
   - After the tick: (x=32, y=0) → 7; (x=32, y=32) → 0.
   - `mode_ready` is 1 the cycle after the tick.
5. **Box drawing and handshake edges.** Mode 3 applied with the box at (0,0).
   - (x=31, y=31) → 3'b110; (x=32, y=0) → 0.
   - A request accepted on the tick cycle applies only at the next tick.
   - `mode_valid` while `mode_ready`=0 is ignored.
6. **Asynchronous reset.** Pending mode set, box moved, `frame_count`=5; pulse `rst_n` low with no clock.
   - All outputs return to their reset values.
   - (x=0, y=0, `de`=1) → bars colour 0.
